// File: rtl/hazard_ctrl_if.sv
// Bundle of the hazard inputs from the ID/EX/MEM stages and the stall/flush
// controls returned to the pipeline registers, plus counters and FSM state.
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       rs1_id;
    logic [4:0]       rs2_id;
    logic             use_rs1_id;
    logic             use_rs2_id;
    logic [4:0]       rd_ex;
    logic             mem_read_ex;
    logic             redirect_ex;
    logic             dmem_req;
    logic             dmem_ack;

    logic             pc_stall;
    logic             if_id_stall;
    logic             if_id_flush;
    logic             id_ex_stall;
    logic             id_ex_flush;
    logic             ex_mem_stall;
    logic             mem_wb_flush;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;
    logic [1:0]       state_dbg;

    // Handshake: none. Controls are level signals valid every cycle; the
    // pipeline acts on them at the rising edge that ends the cycle.
    modport master (
        output rs1_id, rs2_id, use_rs1_id, use_rs2_id, rd_ex, mem_read_ex,
               redirect_ex, dmem_req, dmem_ack,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
               ex_mem_stall, mem_wb_flush, mem_err, stall_cycles, flush_events,
               state_dbg
    );

    modport slave (
        input  rs1_id, rs2_id, use_rs1_id, use_rs2_id, rd_ex, mem_read_ex,
               redirect_ex, dmem_req, dmem_ack,
        output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
               ex_mem_stall, mem_wb_flush, mem_err, stall_cycles, flush_events,
               state_dbg
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, EX redirect flush, data
// memory wait freeze with timeout watchdog, saturating stall/flush counters.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input logic          clk,
    input logic          rst,
    hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    localparam int               WC_W    = $clog2(MEM_TIMEOUT);
    localparam logic [WC_W-1:0]  WC_ONE  = WC_W'(1);
    localparam logic [WC_W-1:0]  WC_LAST = WC_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           r_state;
    state_t           w_next_state;
    logic [WC_W-1:0]  r_wait_cnt;
    logic             r_mem_err;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_mem_busy;
    logic w_freeze;
    logic w_load_use;
    logic w_pc_stall;
    logic w_if_id_stall;
    logic w_if_id_flush;
    logic w_id_ex_stall;
    logic w_id_ex_flush;
    logic w_ex_mem_stall;
    logic w_mem_wb_flush;

    assign w_mem_busy = bus.dmem_req & ~bus.dmem_ack;
    assign w_freeze   = (r_state == ST_ERR) | w_mem_busy;
    assign w_load_use = bus.mem_read_ex & (bus.rd_ex != 5'd0) &
                        ((bus.use_rs1_id & (bus.rs1_id == bus.rd_ex)) |
                         (bus.use_rs2_id & (bus.rs2_id == bus.rd_ex)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_RUN;
        else      r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_RUN:  if (w_mem_busy) w_next_state = ST_WAIT;
            ST_WAIT: begin
                if (!w_mem_busy)                  w_next_state = ST_RUN;
                else if (r_wait_cnt == WC_LAST)   w_next_state = ST_ERR;
            end
            ST_ERR:  w_next_state = ST_ERR;
            default: w_next_state = ST_RUN;
        endcase
    end

    // Freeze beats redirect beats load-use; everything is forced low in reset.
    always_comb begin
        w_pc_stall     = 1'b0;
        w_if_id_stall  = 1'b0;
        w_if_id_flush  = 1'b0;
        w_id_ex_stall  = 1'b0;
        w_id_ex_flush  = 1'b0;
        w_ex_mem_stall = 1'b0;
        w_mem_wb_flush = 1'b0;
        if (rst) begin
            if (w_freeze) begin
                w_pc_stall     = 1'b1;
                w_if_id_stall  = 1'b1;
                w_id_ex_stall  = 1'b1;
                w_ex_mem_stall = 1'b1;
                w_mem_wb_flush = 1'b1;
            end else if (bus.redirect_ex) begin
                w_if_id_flush  = 1'b1;
                w_id_ex_flush  = 1'b1;
            end else if (w_load_use) begin
                w_pc_stall     = 1'b1;
                w_if_id_stall  = 1'b1;
                w_id_ex_flush  = 1'b1;
            end
        end
    end

    // The count includes the RUN->WAIT cycle so ERR lands on the
    // MEM_TIMEOUT-th consecutive busy edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN:  r_wait_cnt <= w_mem_busy ? WC_ONE : '0;
                ST_WAIT: begin
                    if (!w_mem_busy)                 r_wait_cnt <= '0;
                    else if (w_next_state != ST_ERR) r_wait_cnt <= r_wait_cnt + WC_ONE;
                end
                default: r_wait_cnt <= r_wait_cnt;
            endcase
            if (w_next_state == ST_ERR) r_mem_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_pc_stall && (r_stall_cnt != CNT_MAX))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_if_id_flush && (r_flush_cnt != CNT_MAX))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign bus.pc_stall     = w_pc_stall;
    assign bus.if_id_stall  = w_if_id_stall;
    assign bus.if_id_flush  = w_if_id_flush;
    assign bus.id_ex_stall  = w_id_ex_stall;
    assign bus.id_ex_flush  = w_id_ex_flush;
    assign bus.ex_mem_stall = w_ex_mem_stall;
    assign bus.mem_wb_flush = w_mem_wb_flush;
    assign bus.mem_err      = r_mem_err;
    assign bus.stall_cycles = r_stall_cnt;
    assign bus.flush_events = r_flush_cnt;
    assign bus.state_dbg    = r_state;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: the driver pushes hand-computed expected
// output vectors, a negedge monitor pops and compares them.
module tb_hazard_ctrl;
    localparam int W = 18;
    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_FRZ  = 7'b1101011;
    localparam logic [6:0] C_RD   = 7'b0010100;
    localparam logic [6:0] C_LU   = 7'b1100100;
    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ERR  = 2'd2;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    logic [W-1:0] exp_q[$];
    string        name_q[$];

    hazard_ctrl_if #(.CNT_W(4)) bus();

    hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // driver tasks
    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic mr, input logic redir, input logic req,
                         input logic ack);
        bus.rs1_id      = rs1;
        bus.rs2_id      = rs2;
        bus.use_rs1_id  = u1;
        bus.use_rs2_id  = u2;
        bus.rd_ex       = rd;
        bus.mem_read_ex = mr;
        bus.redirect_ex = redir;
        bus.dmem_req    = req;
        bus.dmem_ack    = ack;
    endtask

    task automatic expect_v(input logic [6:0] ctrl, input logic err,
                            input logic [1:0] st, input logic [3:0] sc,
                            input logic [3:0] fc, input string nm);
        exp_q.push_back({ctrl, err, st, sc, fc});
        name_q.push_back(nm);
    endtask

    task automatic cyc(input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic mr, input logic redir, input logic req,
                       input logic ack, input logic [6:0] ctrl, input logic err,
                       input logic [1:0] st, input logic [3:0] sc,
                       input logic [3:0] fc, input string nm);
        @(posedge clk);
        #1;
        drive(rs1, rs2, u1, u2, rd, mr, redir, req, ack);
        expect_v(ctrl, err, st, sc, fc, nm);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        expect_v(C_NONE, 1'b0, S_RUN, 4'd0, 4'd0, "in_reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // scoreboard monitor
    initial begin
        logic [W-1:0] act;
        logic [W-1:0] exp;
        string        nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                nm  = name_q.pop_front();
                act = {bus.pc_stall, bus.if_id_stall, bus.if_id_flush,
                       bus.id_ex_stall, bus.id_ex_flush, bus.ex_mem_stall,
                       bus.mem_wb_flush, bus.mem_err, bus.state_dbg,
                       bus.stall_cycles, bus.flush_events};
                n_checks++;
                if (act !== exp) begin
                    n_fail++;
                    $display("FAIL %s: got %05h expected %05h (ctrl,err,state,stall,flush)",
                             nm, act, exp);
                end
            end
        end
    end

    // stimulus
    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);

        // load-use
        do_reset();
        cyc(5'd3, 5'd5, 1, 1, 5'd5, 1, 0, 0, 0, C_LU,   0, S_RUN, 4'd0, 4'd0, "lu_rs2_hit");
        cyc(5'd3, 5'd5, 1, 1, 5'd5, 0, 0, 0, 0, C_NONE, 0, S_RUN, 4'd1, 4'd0, "lu_cleared");
        cyc(5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 0, 0, C_NONE, 0, S_RUN, 4'd1, 4'd0, "lu_rd_x0");
        cyc(5'd7, 5'd9, 1, 0, 5'd7, 1, 0, 0, 0, C_LU,   0, S_RUN, 4'd1, 4'd0, "lu_rs1_hit");
        cyc(5'd7, 5'd9, 0, 1, 5'd7, 1, 0, 0, 0, C_NONE, 0, S_RUN, 4'd2, 4'd0, "lu_rs1_unused");
        // redirect beats load-use
        cyc(5'd3, 5'd5, 1, 1, 5'd5, 1, 1, 0, 0, C_RD,   0, S_RUN, 4'd2, 4'd0, "redir_over_lu");
        cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, C_NONE, 0, S_RUN, 4'd2, 4'd1, "redir_after");

        // memory wait released on ack
        do_reset();
        cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, C_FRZ,  0, S_RUN,  4'd0, 4'd0, "mw_busy1");
        cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, C_FRZ,  0, S_WAIT, 4'd1, 4'd0, "mw_busy2");
        cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, C_FRZ,  0, S_WAIT, 4'd2, 4'd0, "mw_busy3");
        cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, C_NONE, 0, S_WAIT, 4'd3, 4'd0, "mw_ack");
        cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, C_NONE, 0, S_RUN,  4'd3, 4'd0, "mw_done");

        // redirect held through a freeze
        do_reset();
        cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 0, C_FRZ,  0, S_RUN,  4'd0, 4'd0, "rf_frz1");
        cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 0, C_FRZ,  0, S_WAIT, 4'd1, 4'd0, "rf_frz2");
        cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 1, C_RD,   0, S_WAIT, 4'd2, 4'd0, "rf_ack");
        cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, C_NONE, 0, S_RUN,  4'd2, 4'd1, "rf_done");

        // watchdog
        do_reset();
        cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, C_FRZ, 0, S_RUN,  4'd0, 4'd0, "wd_1");
        cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, C_FRZ, 0, S_WAIT, 4'd1, 4'd0, "wd_2");
        cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, C_FRZ, 0, S_WAIT, 4'd2, 4'd0, "wd_3");
        cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, C_FRZ, 0, S_WAIT, 4'd3, 4'd0, "wd_4");
        cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, C_FRZ, 1, S_ERR,  4'd4, 4'd0, "wd_err_noreq");
        cyc(5'd3, 5'd5, 1, 1, 5'd5, 1, 1, 0, 0, C_FRZ, 1, S_ERR,  4'd5, 4'd0, "wd_err_redir");
        do_reset();
        cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, C_NONE, 0, S_RUN, 4'd0, 4'd0, "wd_post_reset");

        // counter saturation
        do_reset();
        for (int i = 0; i < 20; i++)
            cyc(5'd0, 5'd5, 0, 1, 5'd5, 1, 0, 0, 0, C_LU, 0, S_RUN,
                (i > 15) ? 4'd15 : 4'(i), 4'd0, "sat_stall");
        for (int j = 0; j < 18; j++)
            cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, C_RD, 0, S_RUN,
                4'd15, (j > 15) ? 4'd15 : 4'(j), "sat_flush");
        cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, C_NONE, 0, S_RUN, 4'd15, 4'd15, "sat_hold");

        // drain scoreboard
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
